// File: rtl/testram_pkg.sv
// testram_pkg: shared definitions for the testram slice.
//   - FSM state encoding for the request handshake
//   - maximum supported wait-state count
//   - boot program bytes used when the array is preloaded
//     (ADC #$01 ; JMP $0000)
package testram_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int unsigned WAIT_STATES_MAX = 15;

    localparam logic [7:0] BOOT_B0 = 8'h69;  // ADC #
    localparam logic [7:0] BOOT_B1 = 8'h01;  //   $01
    localparam logic [7:0] BOOT_B2 = 8'h4C;  // JMP
    localparam logic [7:0] BOOT_B3 = 8'h00;  //   lo
    localparam logic [7:0] BOOT_B4 = 8'h00;  //   hi

endpackage

// File: rtl/testram_if.sv
// testram_if: CPU-side request/response bundle for testram.
//   tm_req     : access request (requester -> RAM)
//   tm_rw      : 1 = read, 0 = write (6502 convention)
//   tm_address : 16-bit CPU address
//   tm_wdata   : write data
//   tm_data    : registered read data (RAM -> requester)
//   tm_ready   : one-cycle completion pulse
//   tm_busy    : high while an accepted request is pending
// Modports: master = requester (CPU / bench), slave = testram.
interface testram_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic              tm_req;
    logic              tm_rw;
    logic [15:0]       tm_address;
    logic [DATA_W-1:0] tm_wdata;
    logic [DATA_W-1:0] tm_data;
    logic              tm_ready;
    logic              tm_busy;

    modport master (
        output tm_req,
        output tm_rw,
        output tm_address,
        output tm_wdata,
        input  tm_data,
        input  tm_ready,
        input  tm_busy
    );

    modport slave (
        input  tm_req,
        input  tm_rw,
        input  tm_address,
        input  tm_wdata,
        output tm_data,
        output tm_ready,
        output tm_busy
    );

endinterface

// File: rtl/testram_array.sv
// testram_array: 2**ADDR_W x DATA_W storage with a synchronous write port
// and a registered read port.
//   clk     : clock, rising edge
//   rst     : async active-high; clears only the read register, never the array
//   we_i    : write strobe
//   re_i    : read strobe
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data register, holds until the next read
// Build option: TESTRAM_PRELOAD_EN places the boot program at words 0..4;
// otherwise the array starts all-zero.
module testram_array
    import testram_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Power-up contents are given by the declaration initialiser; the array
    // has no reset so that a reset never disturbs stored data.
`ifdef TESTRAM_PRELOAD_EN
    logic [DATA_W-1:0] mem_q [DEPTH] = '{
        0:       DATA_W'(BOOT_B0),
        1:       DATA_W'(BOOT_B1),
        2:       DATA_W'(BOOT_B2),
        3:       DATA_W'(BOOT_B3),
        4:       DATA_W'(BOOT_B4),
        default: '0
    };
`else
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
`endif

    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/testram.sv
// testram: wait-stated single-port RAM model for a 6502-style CPU bus.
//   clk : clock, rising edge
//   rst : async active-high reset; aborts any pending access
//   bus : testram_if.slave (tm_req/tm_rw/tm_address/tm_wdata in,
//         tm_data/tm_ready/tm_busy out)
// An access is accepted in IDLE, waits WAIT_STATES extra edges in WAIT,
// then completes with a one-cycle tm_ready pulse. Address bits above
// ADDR_W-1 are ignored, so the array mirrors across 64 KiB.
// Build option: TESTRAM_PRELOAD_EN (see testram_array).
module testram
    import testram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic      clk,
    input  logic      rst,
    testram_if.slave  bus
);

    localparam int unsigned CNT_W  = $clog2(WAIT_STATES_MAX + 1);
    localparam int unsigned WS_EFF = (WAIT_STATES > WAIT_STATES_MAX) ?
                                     WAIT_STATES_MAX : WAIT_STATES;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ready_q;
    logic              busy_q;

    logic              done;
    logic [DATA_W-1:0] rdata;

    // Completion edge: the array acts on the same edge that raises tm_ready.
    assign done = (state_q == ST_WAIT) && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.tm_req) begin
                        addr_q  <= bus.tm_address[ADDR_W-1:0];
                        rw_q    <= bus.tm_rw;
                        wdata_q <= bus.tm_wdata;
                        cnt_q   <= CNT_W'(WS_EFF);
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    testram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (done & ~rw_q),
        .re_i    (done & rw_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

    assign bus.tm_data  = rdata;
    assign bus.tm_ready = ready_q;
    assign bus.tm_busy  = busy_q;

    // Upper address bits deliberately do not decode (mirroring).
    if (ADDR_W < 16) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.tm_address[15:ADDR_W];
    end

endmodule

// File: doc/testram.md
TESTRAM -- requirements
Module: testram

Interface
REQ-001 Parameter ADDR_W, default 8: storage depth is 2**ADDR_W words; only tm_address[ADDR_W-1:0] decodes.
REQ-002 Parameter DATA_W, default 8: word width of tm_wdata and tm_data.
REQ-003 Parameter WAIT_STATES, default 0, legal range 0..15: extra cycles inserted before each access completes.
REQ-004 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port: rst, input, 1, reset, asynchronous and active-high.
REQ-006 Port: tm_req, input, 1, access request; sampled only when the block is idle.
REQ-007 Port: tm_rw, input, 1, access direction per the 6502 convention: 1 = read, 0 = write.
REQ-008 Port: tm_address, input, 16, CPU address bus.
REQ-009 Port: tm_wdata, input, DATA_W, write data.
REQ-010 Port: tm_data, output, DATA_W, registered read data.
REQ-011 Port: tm_ready, output, 1, one-cycle completion pulse.
REQ-012 Port: tm_busy, output, 1, high while a request is accepted but not yet completed.

Function
REQ-013 The FSM SHALL have two states: IDLE and WAIT.
REQ-014 In IDLE with tm_req=1 at a rising edge, the block SHALL latch address, rw and wdata, load the counter with WAIT_STATES, and enter WAIT (accept edge).
REQ-015 In WAIT with counter>0, the block SHALL decrement the counter each edge; with counter=0, it SHALL perform the access, pulse tm_ready for exactly one cycle, and return to IDLE.
REQ-016 Latency SHALL be WAIT_STATES+1 edges from the accept edge to the edge that raises tm_ready.
REQ-017 On a read, tm_data SHALL update on the same edge that raises tm_ready and hold its value until the next read completes; writes SHALL NOT change tm_data.
REQ-018 On a write, the latched word SHALL be stored on the completion edge; it SHALL be readable by any request accepted afterwards.
REQ-019 tm_req, tm_address, tm_rw and tm_wdata SHALL be ignored while in WAIT; the requester is not required to hold them after the accept edge.
REQ-020 A request presented during the cycle in which tm_ready is high SHALL be accepted on that edge (back-to-back); sustained throughput is one access per WAIT_STATES+2 cycles.
REQ-021 tm_busy SHALL be high exactly while the state is WAIT.
REQ-022 Address bits above ADDR_W-1 SHALL be ignored, so the array mirrors across the full 64 KiB space (e.g. ADDR_W=8: $0100 aliases $0000).

Reset
REQ-023 rst SHALL force IDLE, counter=0, tm_ready=0, tm_busy=0 and tm_data=0 immediately, without waiting for a clock edge.
REQ-024 Reset asserted during WAIT SHALL abort the request: no write is performed and no tm_ready pulse is produced.
REQ-025 Array contents SHALL NOT be altered by reset.

Configuration
REQ-026 With macro TESTRAM_PRELOAD_EN defined, the array SHALL initialise at time zero to the boot program 69 01 4C 00 00 (ADC #$01; JMP $0000) at words 0..4, with all other words 00.
REQ-027 Without TESTRAM_PRELOAD_EN, the array SHALL initialise to all zeros.

Structure
REQ-028 Shared package testram_pkg SHALL hold the FSM state encodings, the WAIT_STATES maximum (15), and the boot-program byte constants.
REQ-029 The storage array, with its synchronous write port and registered read port, SHALL be a sub-module named testram_array; the FSM, counter and handshake logic SHALL be in testram.

Verification
REQ-030 Preload on, WAIT_STATES=0: read $0000 then $0002 -> tm_data=69 then 4C, each with tm_ready 1 edge after its accept edge.
REQ-031 WAIT_STATES=3: write $12 to $0040, then read $0040 -> tm_busy high for 4 cycles per access; tm_ready on the 4th edge after accept; tm_data=12.
REQ-032 ADDR_W=8: write $A5 to $0105, then read $0005 -> tm_data=A5 (mirroring).
REQ-033 tm_req held high continuously, WAIT_STATES=1 -> one tm_ready every 3 cycles; inputs changed while busy are not captured.
REQ-034 WAIT_STATES=2: rst pulsed mid-write to $0010 -> tm_ready never pulses; tm_busy=0 and tm_data=00 immediately; a later read of $0010 returns its prior value.
REQ-035 Preload off: read $0000 -> tm_data=00.
